// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - opcode constants, input-select codes and state type for uc_seq
package uc_pkg;

    // Exact-match opcodes
    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_JMP  = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_HALT = 6'b011111;

    // Prefix opcodes: low bits carry register/port operands
    localparam logic [3:0] OP_LI   = 4'b0001;   // matched against opcode[5:2]
    localparam logic [3:0] OP_IN   = 4'b0010;   // matched against opcode[5:2]
    localparam logic [3:0] OP_OUT  = 4'b0011;   // matched against opcode[5:2]
    localparam logic [4:0] OP_WAIT = 5'b01010;  // matched against opcode[5:1]

    // WD3 source select
    localparam logic [1:0] SEL_ALU   = 2'b00;
    localparam logic [1:0] SEL_PORT  = 2'b01;
    localparam logic [1:0] SEL_STACK = 2'b10;
    localparam logic [1:0] SEL_IMM   = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } uc_state_t;

endpackage

// File: rtl/uc_wait_timer.sv
// rtl/uc_wait_timer.sv - saturating WAIT cycle counter with clear and expiry compare
module uc_wait_timer #(
    parameter int WAIT_W   = 8,
    parameter int WAIT_MAX = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [WAIT_W-1:0] cnt_q;

    // Count WAIT cycles; clear on WAIT entry, hold at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == WAIT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/uc_seq.sv
// rtl/uc_seq.sv - sequencing control unit for cd (optional WAIT timeout: UC_WAIT_TIMEOUT_EN)
module uc_seq
    import uc_pkg::*;
#(
    parameter int WAIT_W   = 8,
    parameter int WAIT_MAX = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       z,
    input  logic [1:0] in_valid,
    input  logic       resume,
    output logic       s_inc,
    output logic       pc_en,
    output logic       we3,
    output logic       wez,
    output logic       s_we_port,
    output logic [2:0] op_alu,
    output logic [1:0] sel_inputs,
    output logic [1:0] in_ack,
    output logic       halted,
    output logic       illegal,
    output logic       timeout
);

    uc_state_t state_q, state_d;
    logic      illegal_q;
    logic      illegal_set;
    logic      wait_clr;
    logic      wait_port;

    // The stalled PC keeps the WAIT opcode on the bus, so the port is always opcode[0]
    assign wait_port = opcode[0];

`ifdef UC_WAIT_TIMEOUT_EN
    logic timeout_q;
    logic timeout_set;
    logic wait_expired;

    uc_wait_timer #(
        .WAIT_W   (WAIT_W),
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (wait_clr),
        .inc_i     (state_q == ST_WAIT),
        .expired_o (wait_expired)
    );

    assign timeout = timeout_q;
`else
    // Timer parameters only matter when the timeout is built in
    logic unused_cfg;
    assign unused_cfg = (WAIT_W > 0) && (WAIT_MAX > 0);
    assign timeout    = 1'b0;
`endif

    assign illegal = illegal_q;

    // Decode opcode and state into datapath controls and the next state
    always_comb begin
        s_inc       = 1'b1;
        pc_en       = 1'b0;
        we3         = 1'b0;
        wez         = 1'b0;
        s_we_port   = 1'b0;
        op_alu      = 3'b000;
        sel_inputs  = SEL_ALU;
        in_ack      = 2'b00;
        halted      = 1'b0;
        state_d     = state_q;
        illegal_set = 1'b0;
        wait_clr    = 1'b0;
`ifdef UC_WAIT_TIMEOUT_EN
        timeout_set = 1'b0;
`endif
        case (state_q)
            ST_BOOT: begin
                // Bubble while the first instruction is fetched
                state_d = ST_RUN;
            end
            ST_RUN: begin
                pc_en = 1'b1;
                if (opcode[5]) begin
                    op_alu = opcode[4:2];
                    we3    = 1'b1;
                    wez    = 1'b1;
                end else if (opcode == OP_NOP) begin
                    pc_en = 1'b1;
                end else if (opcode[5:2] == OP_LI) begin
                    we3        = 1'b1;
                    sel_inputs = SEL_IMM;
                end else if (opcode[5:2] == OP_IN) begin
                    we3        = 1'b1;
                    sel_inputs = SEL_PORT;
                end else if (opcode[5:2] == OP_OUT) begin
                    s_we_port = 1'b1;
                end else if (opcode == OP_JMP) begin
                    s_inc = 1'b0;
                end else if (opcode == OP_JZ) begin
                    s_inc = ~z;
                end else if (opcode == OP_JNZ) begin
                    s_inc = z;
                end else if (opcode[5:1] == OP_WAIT) begin
                    if (in_valid[wait_port]) begin
                        in_ack[wait_port] = 1'b1;
                    end else begin
                        pc_en    = 1'b0;
                        wait_clr = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end else if (opcode == OP_HALT) begin
                    pc_en   = 1'b0;
                    state_d = ST_HALT;
                end else begin
                    illegal_set = 1'b1;
                end
            end
            ST_WAIT: begin
                if (in_valid[wait_port]) begin
                    in_ack[wait_port] = 1'b1;
                    pc_en             = 1'b1;
                    state_d           = ST_RUN;
                end
`ifdef UC_WAIT_TIMEOUT_EN
                else if (wait_expired) begin
                    pc_en       = 1'b1;
                    timeout_set = 1'b1;
                    state_d     = ST_RUN;
                end
`endif
            end
            ST_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    pc_en   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State register and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_BOOT;
            illegal_q <= 1'b0;
`ifdef UC_WAIT_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
`ifdef UC_WAIT_TIMEOUT_EN
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
`endif
        end
    end

endmodule
